// File: rtl/serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_seq
// Purpose  : Bit-serial ALU sequencer. Evaluates AND/OR/ADD/SUB/SLT on
//            WIDTH-bit operands one bit per clock through a single 1-bit
//            slice, then publishes the word result with carry, overflow
//            and zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module serial_alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_OP_AND = 2'b00;
    localparam logic [1:0] c_OP_OR  = 2'b01;
    localparam logic [1:0] c_OP_ADD = 2'b10;
    localparam logic [1:0] c_OP_SLT = 2'b11;

    // Index of the MSB; reaching it ends the RUN phase.
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;        // operand A, shifted right so bit 0 is current
    logic [WIDTH-1:0] r_b;        // operand B, shifted right so bit 0 is current
    logic [2:0]       r_op;
    logic             r_c;        // ripple carry into the current bit
    logic [CNT_W-1:0] r_idx;      // bit currently being processed
    logic [WIDTH-1:0] r_sr;       // result shift register, filled LSB-first

    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_bi;
    logic             w_sum;
    logic             w_cnext;
    logic             w_slice;
    logic             w_ovf;
    logic             w_last;
    logic [WIDTH-1:0] w_sr_next;
    logic [WIDTH-1:0] w_result_next;

    // 1-bit slice: conditional B inversion, full adder and operation select.
    always_comb begin
        w_bi    = r_b[0] ^ r_op[2];
        w_sum   = r_a[0] ^ w_bi ^ r_c;
        w_cnext = (r_a[0] & w_bi) | (r_a[0] & r_c) | (w_bi & r_c);
        w_slice = 1'b0;
        case (r_op[1:0])
            c_OP_AND: w_slice = r_a[0] & w_bi;
            c_OP_OR:  w_slice = r_a[0] | w_bi;
            c_OP_ADD: w_slice = w_sum;
            c_OP_SLT: w_slice = 1'b0;   // filled in from the MSB sum at the end
            default:  w_slice = 1'b0;
        endcase
    end

    // Word-level results as they would appear after the final (MSB) bit.
    // At the MSB, r_c is the carry into the MSB, so its XOR with the carry out
    // is signed overflow; sum_msb ^ overflow gives a signed less-than that
    // stays correct when the subtraction overflows.
    always_comb begin
        w_last        = (r_idx == c_LAST);
        w_ovf         = r_c ^ w_cnext;
        w_sr_next     = {w_slice, r_sr[WIDTH-1:1]};
        w_result_next = w_sr_next;
        if (r_op[1:0] == c_OP_SLT) begin
            w_result_next = {{(WIDTH-1){1'b0}}, w_sum ^ w_ovf};
        end
    end

    // Sequencer state: IDLE accepts a request, RUN walks WIDTH bits, DONE pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (start) r_state <= c_RUN;
                c_RUN:   if (w_last) r_state <= c_DONE;
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Operand capture on accept, then one bit shifted through the slice per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_c   <= 1'b0;
            r_idx <= '0;
            r_sr  <= '0;
        end else if (r_state == c_IDLE) begin
            if (start) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= op;
                r_c   <= op[2];          // binvert doubles as carry-in for SUB/SLT
                r_idx <= '0;
                r_sr  <= '0;
            end
        end else if (r_state == c_RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_c   <= w_cnext;
            r_sr  <= w_sr_next;
            r_idx <= r_idx + CNT_W'(1);
        end
    end

    // Published outputs change only on the last RUN edge, so partial results never leak.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b1;
        end else if ((r_state == c_RUN) && w_last) begin
            r_result <= w_result_next;
            r_cout   <= w_cnext;
            r_ovf    <= w_ovf;
            r_zero   <= (w_result_next == '0);
        end
    end

    assign busy     = (r_state == c_RUN);
    assign done     = (r_state == c_DONE);
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_alu_seq
// Purpose  : Self-checking bench for serial_alu_seq at WIDTH=8. Expected
//            results are queued when an operation is issued and compared
//            when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_alu_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    serial_alu_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .op       (op),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       co;
        logic       ov;
        logic       z;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        exp_t       e;
    } vec_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Independent word-level reference: two's-complement add of a and (optionally inverted) b.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t       r;
        logic [7:0] yi;
        logic [8:0] s;
        yi   = o[2] ? ~y : y;
        s    = {1'b0, x} + {1'b0, yi} + {8'd0, o[2]};
        r.co = s[8];
        r.ov = (x[7] == yi[7]) && (s[7] != x[7]);
        case (o[1:0])
            2'b00:   r.res = x & yi;
            2'b01:   r.res = x | yi;
            2'b10:   r.res = s[7:0];
            default: r.res = {7'd0, s[7] ^ r.ov};
        endcase
        r.z = (r.res == 8'd0);
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: compare against the oldest queued expectation on each done.
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            done_cnt++;
            chk("sb_nonempty", (q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("result",   result,   e.res);
                chk("cout",     cout,     e.co);
                chk("overflow", overflow, e.ov);
                chk("zero",     zero,     e.z);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 30);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input exp_t e);
        wait_idle();
        start = 1'b1; a = x; b = y; op = o;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    vec_t vecs[11];

    initial begin
        int   n, bc, t1, t2, dc0;
        exp_t e;

        vecs[0]  = '{3'b010, 8'h7F, 8'h01, '{8'h80, 1'b0, 1'b1, 1'b0}};
        vecs[1]  = '{3'b110, 8'h05, 8'h05, '{8'h00, 1'b1, 1'b0, 1'b1}};
        vecs[2]  = '{3'b110, 8'h80, 8'h01, '{8'h7F, 1'b1, 1'b1, 1'b0}};
        vecs[3]  = '{3'b111, 8'hFE, 8'h03, '{8'h01, 1'b1, 1'b0, 1'b0}};
        vecs[4]  = '{3'b111, 8'h7F, 8'h80, '{8'h00, 1'b0, 1'b1, 1'b1}};
        vecs[5]  = '{3'b111, 8'h80, 8'h7F, '{8'h01, 1'b1, 1'b1, 1'b0}};
        vecs[6]  = '{3'b000, 8'hF0, 8'h3C, '{8'h30, 1'b1, 1'b0, 1'b0}};
        vecs[7]  = '{3'b001, 8'hF0, 8'h3C, '{8'hFC, 1'b1, 1'b0, 1'b0}};
        vecs[8]  = '{3'b100, 8'hF0, 8'h3C, '{8'hC0, 1'b1, 1'b0, 1'b0}};
        vecs[9]  = '{3'b101, 8'hF0, 8'h3C, '{8'hF3, 1'b1, 1'b0, 1'b0}};
        vecs[10] = '{3'b010, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b0, 1'b1}};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   busy,     0);
        chk("rst_done",   done,     0);
        chk("rst_result", result,   0);
        chk("rst_zero",   zero,     1);
        chk("rst_cout",   cout,     0);
        chk("rst_ovf",    overflow, 0);
        reset = 1'b0;

        // Latency and busy width on ADD 0x7F + 0x01.
        wait_idle();
        start = 1'b1; a = 8'h7F; b = 8'h01; op = 3'b010;
        q.push_back(vecs[0].e);
        @(posedge clk);
        #1;
        start = 1'b0;
        n  = 1;
        bc = busy ? 1 : 0;
        while (!done && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bc++;
        end
        chk("latency_edges", n, 9);
        chk("busy_cycles",   bc, 8);

        // Table-driven vectors.
        for (int i = 1; i < 11; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
        end

        // Random vectors against the reference model.
        for (int i = 0; i < 20; i++) begin
            logic [2:0] ro;
            logic [7:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op(ro, ra, rb, model(ro, ra, rb));
        end

        // Reset in the middle of RUN after a nonzero result is on the outputs.
        do_op(3'b010, 8'h12, 8'h34, model(3'b010, 8'h12, 8'h34));
        wait_idle();
        start = 1'b1; a = 8'h12; b = 8'h34; op = 3'b010;
        @(posedge clk);            // E0
        #1;
        start = 1'b0;
        @(posedge clk);            // E1
        @(posedge clk);            // E2
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy",   busy,   0);
        chk("midrst_done",   done,   0);
        chk("midrst_result", result, 0);
        chk("midrst_zero",   zero,   1);
        @(negedge clk);
        reset = 1'b0;
        dc0 = done_cnt;
        repeat (14) @(negedge clk);
        chk("midrst_no_done", done_cnt - dc0, 0);
        do_op(3'b010, 8'h12, 8'h34, '{8'h46, 1'b0, 1'b0, 1'b0});

        // Start pulsed mid-RUN with other operands must be ignored.
        wait_idle();
        dc0 = done_cnt;
        start = 1'b1; a = 8'h12; b = 8'h34; op = 3'b010;
        q.push_back('{8'h46, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'b001;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (15) @(negedge clk);
        chk("busy_start_one_done", done_cnt - dc0, 1);

        // Back-to-back with start held high: AND then OR.
        wait_idle();
        dc0 = done_cnt;
        start = 1'b1; a = 8'hF0; b = 8'h3C; op = 3'b000;
        q.push_back(vecs[6].e);
        wait_done();
        t1 = cyc;
        op = 3'b001;
        q.push_back(vecs[7].e);
        wait_done();
        t2 = cyc;
        start = 1'b0;
        chk("b2b_spacing", t2 - t1, 10);
        repeat (3) @(negedge clk);
        chk("b2b_done_count", done_cnt - dc0, 2);

        repeat (4) @(negedge clk);
        chk("sb_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
